jk_button_conditioner: RTL

- Upstream stage of the two-state on/off controller: turns two raw, asynchronous, bouncing push-buttons ("on" and "off") into clean single-cycle j/k request pulses.
- Per channel: 2-flop synchroniser, debounce counter and press/release state machine.
- Outputs j and k drive the on/off FSM's j/k inputs directly in the same clock domain.

---
 rtl/jk_button_conditioner.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/jk_button_conditioner.sv
// jk_button_conditioner: two raw, bouncing push-buttons in, clean single-cycle
// j/k request pulses out. Each button has a 2-flop synchroniser, an 8-bit
// debounce counter and a press/release state machine. Accepts from the two
// channels are arbitrated so that j and k are never high together.
// Optional build macro: JK_COND_HOLD_REPEAT_EN enables auto-repeat accepts
// every REPEAT_CYCLES cycles while a button stays pressed.

module jk_btn_channel #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic areset_n,
    input  logic raw_i,
    output logic accept_o,
    output logic level_o
);
    // state         | meaning
    // ST_RELEASED   | button idle, waiting for a synchronised 1
    // ST_PRESS_WAIT | counting stable 1 samples before accepting a press
    // ST_PRESSED    | press accepted, debounced level high
    // ST_RELEASE_WAIT | counting stable 0 samples before accepting a release
    localparam logic [1:0] ST_RELEASED     = 2'b00;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
    localparam logic [1:0] ST_PRESSED      = 2'b10;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
        $error("jk_btn_channel: DEB_CYCLES or REPEAT_CYCLES out of range");
    end

    logic       s1_q, s2_q;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       deb_accept;
    logic       rpt_fire;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce state machine next-state and press-accept decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        deb_accept = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = ST_PRESSED;
                    deb_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                if (s2_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef JK_COND_HOLD_REPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);

    logic [15:0] rpt_q, rpt_d;

    // Repeat counter: runs only in PRESSED with s2 high, frozen in
    // RELEASE_WAIT, cleared on the way into PRESSED from PRESS_WAIT.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        case (state_q)
            ST_RELEASED, ST_PRESS_WAIT: rpt_d = 16'd0;
            ST_PRESSED: begin
                if (s2_q) begin
                    if (rpt_q == RPT_LAST) begin
                        rpt_fire = 1'b1;
                        rpt_d    = 16'd0;
                    end else begin
                        rpt_d = rpt_q + 16'd1;
                    end
                end
            end
            default: rpt_d = rpt_q;
        endcase
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rpt_q <= 16'd0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign accept_o = deb_accept | rpt_fire;
    assign level_o  = state_q[1];
endmodule

module jk_button_conditioner #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic areset_n,
    input  logic btn_on_raw,
    input  logic btn_off_raw,
    output logic j,
    output logic k,
    output logic on_level,
    output logic off_level,
    output logic conflict
);
    logic on_acc, off_acc;
    logic j_q, k_q, conflict_q;

    jk_btn_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_on (
        .clk      (clk),
        .areset_n (areset_n),
        .raw_i    (btn_on_raw),
        .accept_o (on_acc),
        .level_o  (on_level)
    );

    jk_btn_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_off (
        .clk      (clk),
        .areset_n (areset_n),
        .raw_i    (btn_off_raw),
        .accept_o (off_acc),
        .level_o  (off_level)
    );

    // Arbitration: simultaneous accepts cancel each other and raise conflict
    // so the downstream on/off FSM never sees j and k together.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            j_q        <= on_acc & ~off_acc;
            k_q        <= off_acc & ~on_acc;
            conflict_q <= on_acc & off_acc;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign conflict = conflict_q;
endmodule
